forwarding_hazard_unit: RTL

//   Producer of the 2-bit forwarding selects consumed by the EX-stage operand muxes, and of the load-use stall.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/forwarding_select.sv | 24 ++
 rtl/forwarding_hazard_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Types shared between the forwarding/hazard unit and the EX-stage operand muxes.
package riscv_pkg;

    localparam int RF_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b01
    } fwd_sel_t;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '{rd: '0, reg_write: 1'b0, mem_read: 1'b0};

endpackage

// File: rtl/forwarding_select.sv
// Operand forwarding select for one source register; the newest in-flight producer wins.
module forwarding_select
    import riscv_pkg::*;
(
    input  logic [RF_ADDR_W-1:0] src,
    input  logic                 uses,
    input  stage_tag_t           ex_tag,
    input  stage_tag_t           mem_tag,
    output fwd_sel_t             sel
);

    always_comb begin
        // NOTE: a default before any branch keeps this purely combinational (no latch).
        sel = FWD_RF;
        if (uses && src != '0) begin
            if (ex_tag.reg_write && ex_tag.rd == src) begin
                sel = FWD_MEM;
            end else if (mem_tag.reg_write && mem_tag.rd == src) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Shadow EX/MEM/WB destination tags, registered forwarding selects, load-use stall and stall counter.
module forwarding_hazard_unit
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_W = RF_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  ex_flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic [CNT_W-1:0]      stall_count
);

    stage_tag_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    fwd_sel_t         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    fwd_sel_t         sel_a, sel_b;
    logic             bubble_q, bubble_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             luh;

    forwarding_select u_sel_a (
        .src     (id_rs1),
        .uses    (id_valid & id_uses_rs1),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .sel     (sel_a)
    );

    forwarding_select u_sel_b (
        .src     (id_rs2),
        .uses    (id_valid & id_uses_rs2),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .sel     (sel_b)
    );

    // Load in EX whose result the ID instruction needs: data only exists after MEM.
    assign luh = id_valid & ex_q.mem_read & (ex_q.rd != '0) &
                 ((id_uses_rs1 & (id_rs1 == ex_q.rd)) | (id_uses_rs2 & (id_rs2 == ex_q.rd)));

    assign stall_if_id = luh & ~ex_flush & ~hold;

    always_comb begin
        ex_d     = ex_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        fwd_a_d  = fwd_a_q;
        fwd_b_d  = fwd_b_q;
        bubble_d = bubble_q;
        cnt_d    = cnt_q;
        if (!hold) begin
            mem_d = ex_q;
            wb_d  = mem_q;
            if (ex_flush || luh) begin
                ex_d     = TAG_BUBBLE;
                fwd_a_d  = FWD_RF;
                fwd_b_d  = FWD_RF;
                bubble_d = 1'b1;
            end else begin
                ex_d.rd        = id_rd;
                ex_d.reg_write = id_reg_write & id_valid;
                ex_d.mem_read  = id_mem_read & id_valid;
                fwd_a_d        = sel_a;
                fwd_b_d        = sel_b;
                bubble_d       = 1'b0;
            end
            if (stall_if_id && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q     <= TAG_BUBBLE;
            mem_q    <= TAG_BUBBLE;
            wb_q     <= TAG_BUBBLE;
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
            bubble_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            bubble_q <= bubble_d;
            cnt_q    <= cnt_d;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign bubble_ex   = bubble_q;
    assign stall_count = cnt_q;

endmodule
